calc_display: RTL and testbench
===============================

Name: calc_display

Overview:
Output-side counterpart to the calculator's switch/key operand capture. Accepts a binary value (operand echo or ALU result) with a valid strobe and converts it to BCD with a sequential double-dabble. Drives a time-multiplexed common-anode 7-segment display. Sits between the calculator datapath and the board's segment/anode pins.

Parameters:
WIDTH, 8, binary input width; the calculator's largest result is 15*15=225.
DIGITS, 3, number of displayed digits; 10^DIGITS must exceed 2^WIDTH-1; elaboration error otherwise.
REFRESH_DIV, 50000, clk cycles each digit stays enabled; minimum 2.
SEG_ACTIVE_LOW, 1, 1 drives segments and anodes active-low; 0 drives them active-high.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
value_in  in  WIDTH  unsigned binary value to display
value_valid  in  1  single-cycle strobe; value_in is sampled on this cycle
busy  out  1  conversion in progress
seg  out  8  seg[0..6]=a..g, seg[7]=dp; dp is always off
an  out  DIGITS  one-hot digit enable; an[0] is the units digit

Behaviour:
- Reset values: busy=0, BCD display regs=0, pending flag=0, digit index=0, refresh counter=0, FSM=IDLE. seg and an are all inactive in the reset cycle and in the first cycle after reset.
- FSM has two states, IDLE and CONV.
- IDLE with value_valid=1: capture value_in, go to CONV, busy=1 on the next cycle.
- CONV runs WIDTH shift iterations, one per cycle. Before each shift, add 3 to any BCD nibble that is >=5.
- After the final iteration, all DIGITS display regs update in one cycle (atomic commit), so no torn display values.
- Commit occurs WIDTH+1 rising edges after the accept edge. busy drops in the cycle after commit. FSM returns to IDLE.
- value_valid while busy: value goes to a one-deep pending register, last write wins, pending flag set.
- On commit with the pending flag set, CONV restarts directly from the pending value. busy stays high continuously and the pending flag clears.
- value_valid in the same cycle as commit counts as pending and is not lost.
- Scan: the refresh counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments and wraps from DIGITS-1 to 0.
- an and seg are registered: both update in the same cycle, with one cycle of latency from the index. No ghosting between digits.
- Segment decode covers digits 0-9. A nibble >9 (unreachable) shows blank.
- seg and an polarity follow SEG_ACTIVE_LOW.
- Reset asserted mid-conversion: the conversion aborts, pending is dropped, and the display shows 0.

Optional Feature:
Macro CALC_DISP_LZB_EN enables leading-zero blanking.
- Defined: any digit above the units that is 0, with all more-significant digits also 0, shows blank segments. Its anode is still scanned. The units digit is always shown. Example: 7 displays as blank, blank, 7.
- Undefined: all digits are decoded. Example: 7 displays as 0,0,7.

Decomposition:
- Shared package calc_pkg holds:
  - SEG_DIGIT[0:9] segment constants (a..g, active-high form)
  - SEG_BLANK
  - FSM state enum {IDLE, CONV}
  - BCD nibble typedef
- One sub-module, calc_bin2bcd: the sequential double-dabble.
  - Inputs: start, bin. Outputs: done pulse, bcd.
  - calc_display instantiates it and owns pending, scan and decode.

Test Plan:
- Reset, then value_valid with value_in=225, REFRESH_DIV=4 → busy high for 9 cycles. After commit, a full scan shows an[0]=5, an[1]=2, an[2]=2 segment codes, with each an low for exactly 4 cycles.
- value_valid with 0 → with the macro, only the units digit shows "0" and the other digits are blank. Without the macro, 0,0,0 is shown.
- Strobe 12, then strobe 99 at busy cycle 3, then 150 at busy cycle 5 → the display commits 12, then 150. 99 is never displayed. busy stays high continuously through both conversions.
- Strobe in the exact commit cycle of a running conversion → the new value is converted next and is not lost.
- Assert rst at CONV cycle 4 of value 200 → the next cycle shows busy=0 and all outputs inactive. After release, the display shows 0, not 200.
- SEG_ACTIVE_LOW=0 build with value 8 → the units digit has seg=8'h7F and an=3'b001 during its scan slot.

Source files
------------

// File: rtl/calc_pkg.sv
// Purpose : shared types and constants for the calculator display path.
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   calc_state_t - display controller FSM states (IDLE, CONV)
//   bcd_nib_t    - one BCD digit
//   SEG_DIGIT    - active-high segment patterns for digits 0..9, bit0=a .. bit6=g, bit7=dp
//   SEG_BLANK    - all segments off (active-high form)
//   seg_of()     - nibble to segment pattern; nibbles above 9 show blank
//   digits_fit() - true when 10^digits exceeds 2^width-1
package calc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } calc_state_t;

    typedef logic [3:0] bcd_nib_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // dp (bit 7) is never lit.
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    function automatic logic [7:0] seg_of(input bcd_nib_t nib);
        logic [7:0] pat;
        pat = SEG_BLANK;
        if (nib <= 4'd9) begin
            pat = SEG_DIGIT[nib];
        end
        return pat;
    endfunction

    function automatic bit digits_fit(input int width, input int digits);
        longint pow10;
        longint max_bin;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << width) - 1;
        return (pow10 > max_bin);
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Purpose : sequential double-dabble binary to BCD converter.
// Latency : done pulses WIDTH+1 cycles after the start cycle; bcd is valid while done is high.
// Backpressure: none; start is only honoured by the parent when idle or on done, a start restarts.
//
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_start       - load i_bin and begin a conversion
//   i_bin         - unsigned binary input (WIDTH bits)
//   o_done        - single-cycle pulse, o_bcd holds the finished result in this cycle
//   o_bcd         - DIGITS packed BCD nibbles, units in bits [3:0]
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_bin,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]           r_shift;
    bcd_nib_t [DIGITS-1:0]      r_bcd;
    logic [CNTW-1:0]            r_cnt;
    logic                       r_run;
    logic                       r_done;

    bcd_nib_t [DIGITS-1:0]      w_adj;
    logic [4*DIGITS-1:0]        w_adj_flat;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[k] >= 4'd5) begin
                w_adj[k] = r_bcd[k] + 4'd3;
            end
        end
        w_adj_flat = w_adj;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_shift <= i_bin;
                r_bcd   <= '0;
                r_cnt   <= '0;
                r_run   <= 1'b1;
            end else if (r_run) begin
                r_bcd   <= {w_adj_flat[4*DIGITS-2:0], r_shift[WIDTH-1]};
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == CNTW'(WIDTH - 1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/calc_display.sv
// Purpose : binary value to multiplexed common-anode 7-segment display (BCD convert, hold, scan, decode).
// Latency : display commits WIDTH+1 edges after the accept edge; seg/an lag the digit index by one cycle.
// Backpressure: none; strobes while busy land in a one-deep last-write-wins pending register.
//
// Ports:
//   i_clk, i_rst    - clock, synchronous active-high reset
//   i_value_in      - unsigned binary value (WIDTH bits)
//   i_value_valid   - single-cycle strobe qualifying i_value_in
//   o_busy          - a conversion is in progress
//   o_seg           - {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW, dp always off
//   o_an            - one-hot digit enable, o_an[0] = units digit, polarity set by SEG_ACTIVE_LOW
//
// Build option: define CALC_DISP_LZB_EN for leading-zero blanking (units digit always shown).
module calc_display
    import calc_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH-1:0]     i_value_in,
    input  logic                 i_value_valid,
    output logic                 o_busy,
    output logic [7:0]           o_seg,
    output logic [DIGITS-1:0]    o_an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam bit ACT_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic [7:0]        SEG_OFF = ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

`ifdef CALC_DISP_LZB_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
        $error("calc_display: DIGITS too small to show 2^WIDTH-1");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("calc_display: REFRESH_DIV must be at least 2");
    end

    // ---------------------------------------------------------------
    // Conversion control
    // ---------------------------------------------------------------
    calc_state_t              r_state;
    calc_state_t              w_state_nxt;
    logic                     w_start;
    logic [WIDTH-1:0]         w_start_val;
    logic                     w_done;
    logic [4*DIGITS-1:0]      w_bcd;

    logic [WIDTH-1:0]         r_pend;
    logic                     r_pend_vld;
    bcd_nib_t [DIGITS-1:0]    r_disp;

    calc_bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_bin   (w_start_val),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // On done, a strobe in the same cycle beats the stored pending value
    // (it is the later write) and the converter restarts without leaving CONV.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_val = i_value_in;
        case (r_state)
            IDLE: begin
                if (i_value_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (w_done) begin
                    if (i_value_valid || r_pend_vld) begin
                        w_start     = 1'b1;
                        w_start_val = i_value_valid ? i_value_in : r_pend;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (r_state == CONV) begin
            if (w_done) begin
                r_pend_vld <= 1'b0;
            end else if (i_value_valid) begin
                r_pend     <= i_value_in;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // All digits update together so the scan never shows a half-written value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp <= '0;
        end else if (w_done) begin
            r_disp <= w_bcd;
        end
    end

    assign o_busy = (r_state == CONV);

    // ---------------------------------------------------------------
    // Scan
    // ---------------------------------------------------------------
    logic [CW-1:0]   r_refresh;
    logic [IW-1:0]   r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            if (r_idx == IW'(DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    bcd_nib_t            w_nib;
    logic                w_upper_zero;
    logic                w_lead_blank;
    logic [7:0]          w_seg_pat;
    logic [DIGITS-1:0]   w_an_pat;

    // w_upper_zero: the selected digit and every more-significant digit are 0.
    always_comb begin
        w_nib        = '0;
        w_upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(r_idx) == k) begin
                w_nib = r_disp[k];
            end
            if ((k >= int'(r_idx)) && (r_disp[k] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_lead_blank = LZB_EN && (r_idx != '0) && w_upper_zero;
        w_seg_pat    = w_lead_blank ? SEG_BLANK : seg_of(w_nib);
        w_an_pat     = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
    end

    // ---------------------------------------------------------------
    // Output registers: seg and an change on the same edge.
    // r_out_en holds the outputs dark for one extra cycle after reset.
    // ---------------------------------------------------------------
    logic                r_out_en;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_en <= 1'b0;
            r_seg    <= SEG_OFF;
            r_an     <= AN_OFF;
        end else begin
            r_out_en <= 1'b1;
            if (!r_out_en) begin
                r_seg <= SEG_OFF;
                r_an  <= AN_OFF;
            end else begin
                r_seg <= ACT_LOW ? ~w_seg_pat : w_seg_pat;
                r_an  <= ACT_LOW ? ~w_an_pat  : w_an_pat;
            end
        end
    end

    assign o_seg = r_seg;
    assign o_an  = r_an;

endmodule

// File: tb/tb_calc_display.sv
module tb_calc_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] vin = 8'd0;
    logic       vld = 1'b0;
    logic [7:0] vin_hi = 8'd0;
    logic       vld_hi = 1'b0;

    logic       busy, busy_hi;
    logic [7:0] seg, seg_hi;
    logic [2:0] an, an_hi;

    int tests = 0;
    int fails = 0;
    int n;
    int w;

`ifdef CALC_DISP_LZB_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    always #5 clk = ~clk;

    calc_display #(
        .WIDTH(8), .DIGITS(3), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_value_in(vin), .i_value_valid(vld),
        .o_busy(busy), .o_seg(seg), .o_an(an)
    );

    calc_display #(
        .WIDTH(8), .DIGITS(3), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)
    ) u_dut_hi (
        .i_clk(clk), .i_rst(rst), .i_value_in(vin_hi), .i_value_valid(vld_hi),
        .o_busy(busy_hi), .o_seg(seg_hi), .o_an(an_hi)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    // Wait out any slot already in progress, then for a fresh slot of an_exp.
    task automatic scan_slot(input string tag, input logic [2:0] an_exp,
                             input logic [7:0] seg_exp, input bit chk_len);
        int wt;
        int len;
        wt = 0;
        while (an === an_exp && wt < 50) begin wt++; tick(); end
        while (an !== an_exp && wt < 50) begin wt++; tick(); end
        chk({tag, " an"}, {29'd0, an}, {29'd0, an_exp});
        chk({tag, " seg"}, {24'd0, seg}, {24'd0, seg_exp});
        if (chk_len) begin
            len = 0;
            while (an === an_exp && len < 50) begin len++; tick(); end
            chk({tag, " slot len"}, len, 4);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst an", {29'd0, an}, 32'h7);
        chk("rst seg", {24'd0, seg}, 32'hFF);
        chk("rst an_hi", {29'd0, an_hi}, 0);
        rst = 1'b0;
        tick();
        chk("post-rst an", {29'd0, an}, 32'h7);
        chk("post-rst seg", {24'd0, seg}, 32'hFF);
        tick();
        chk("first scan an", {29'd0, an}, 32'h6);
        chk("first scan seg", {24'd0, seg}, 32'hC0);

        // 225: busy for WIDTH+1 cycles, then 5,2,2 with 4-cycle slots
        vin = 8'd225; vld = 1'b1; tick(); vld = 1'b0;
        count_busy(n);
        chk("225 busy cycles", n, 9);
        scan_slot("225 d0", 3'b110, 8'h92, 1'b1);
        scan_slot("225 d1", 3'b101, 8'hA4, 1'b1);
        scan_slot("225 d2", 3'b011, 8'hA4, 1'b1);

        // 0
        vin = 8'd0; vld = 1'b1; tick(); vld = 1'b0;
        count_busy(n);
        chk("zero busy cycles", n, 9);
        scan_slot("zero d0", 3'b110, 8'hC0, 1'b0);
        scan_slot("zero d1", 3'b101, LZ, 1'b0);
        scan_slot("zero d2", 3'b011, LZ, 1'b0);

        // 12, then 99 at busy cycle 3, 150 at busy cycle 5: 150 wins
        vin = 8'd12; vld = 1'b1; tick(); vld = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            vld = (n == 2 || n == 4);
            vin = (n == 2) ? 8'd99 : 8'd150;
            n++;
            tick();
        end
        vld = 1'b0;
        chk("pend busy cycles", n, 18);
        scan_slot("150 d0", 3'b110, 8'hC0, 1'b0);
        scan_slot("150 d1", 3'b101, 8'h92, 1'b0);
        scan_slot("150 d2", 3'b011, 8'hF9, 1'b0);

        // Strobe exactly in the commit cycle (busy cycle 9)
        vin = 8'd37; vld = 1'b1; tick(); vld = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            vld = (n == 8);
            vin = 8'd200;
            n++;
            tick();
        end
        vld = 1'b0;
        chk("commit-strobe busy cycles", n, 18);
        scan_slot("200 d0", 3'b110, 8'hC0, 1'b0);
        scan_slot("200 d1", 3'b101, 8'hC0, 1'b0);
        scan_slot("200 d2", 3'b011, 8'hA4, 1'b0);

        // Display 37 first so a reset visibly clears it, then abort a conversion of 200
        vin = 8'd37; vld = 1'b1; tick(); vld = 1'b0;
        count_busy(n);
        scan_slot("37 d1", 3'b101, 8'hB0, 1'b0);
        vin = 8'd200; vld = 1'b1; tick(); vld = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid-conv busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort an", {29'd0, an}, 32'h7);
        chk("abort seg", {24'd0, seg}, 32'hFF);
        rst = 1'b0;
        tick();
        scan_slot("abort d0", 3'b110, 8'hC0, 1'b0);
        scan_slot("abort d1", 3'b101, LZ, 1'b0);
        scan_slot("abort d2", 3'b011, LZ, 1'b0);
        chk("abort stays idle", {31'd0, busy}, 0);

        // Active-high build, value 8
        vin_hi = 8'd8; vld_hi = 1'b1; tick(); vld_hi = 1'b0;
        w = 0;
        while (busy_hi === 1'b1 && w < 50) begin w++; tick(); end
        while (an_hi === 3'b001 && w < 100) begin w++; tick(); end
        while (an_hi !== 3'b001 && w < 100) begin w++; tick(); end
        chk("hi an", {29'd0, an_hi}, 32'h1);
        chk("hi seg", {24'd0, seg_hi}, 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
